// File: rtl/lcd_bus_scheduler_if.sv
// lcd_bus_scheduler_if: client request/ack ports and LCD pin bundle.
// master = client/display side driving requests, slave = the scheduler.
interface lcd_bus_scheduler_if;
  logic       req0;
  logic       rs0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic       rs1;
  logic [7:0] data1;
  logic       ack1;
  logic [7:0] d;
  logic       e;
  logic       rs;
  logic       busy;
  logic       init_done;

  modport master (
    output req0, rs0, data0, req1, rs1, data1,
    input  ack0, ack1, d, e, rs, busy, init_done
  );

  modport slave (
    input  req0, rs0, data0, req1, rs1, data1,
    output ack0, ack1, d, e, rs, busy, init_done
  );
endinterface

// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler: owns the HD44780 8-bit bus, round-robin arbitrates two
// write clients and generates E strobe timing plus per-command exec waits.
// Optional macro LCD_INIT_SEQ_EN: power-up wait and built-in init command list.
module lcd_bus_scheduler #(
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned EHIGH_CYC     = 24,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 80000,
  parameter int unsigned POWERUP_CYC   = 800000
) (
  input logic               clk,
  input logic               reset,
  lcd_bus_scheduler_if.slave bus
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(SETUP_CYC, EHIGH_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                         max2(LONG_EXEC_CYC, POWERUP_CYC));
  localparam int unsigned CW = $clog2(MAX_CYC) + 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SETUP     = 3'd1;
  localparam logic [2:0] EHIGH     = 3'd2;
  localparam logic [2:0] HOLD      = 3'd3;
  localparam logic [2:0] EXEC      = 3'd4;
`ifdef LCD_INIT_SEQ_EN
  localparam logic [2:0] INIT_WAIT = 3'd5;
  localparam logic [2:0] RST_STATE = INIT_WAIT;

  // Built-in power-up command list: function set x3, display on, clear, entry mode.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction

  logic [2:0] idx_q, idx_n;
`else
  localparam logic [2:0] RST_STATE = IDLE;
`endif

  logic [2:0]    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [7:0]    d_q, d_n;
  logic          rs_q, rs_n;
  logic          e_q, e_n;
  logic          busy_q, busy_n;
  logic          ack0_q, ack0_n;
  logic          ack1_q, ack1_n;
  logic          init_done_q, init_done_n;
  logic          last_q, last_n;
  logic          pick1;
  logic          long_exec;
  logic [CW-1:0] exec_last;

  // Clear/home commands (0x01..0x03 with rs=0) need the long execution wait.
  assign long_exec = !rs_q && (d_q[7:2] == 6'd0) && (d_q[1:0] != 2'd0);
  assign exec_last = long_exec ? CW'(LONG_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
  // Port 1 wins when alone, or when both request and port 0 won last.
  assign pick1     = bus.req1 && (!bus.req0 || !last_q);

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q + CW'(1);
    d_n         = d_q;
    rs_n        = rs_q;
    e_n         = 1'b0;
    busy_n      = busy_q;
    ack0_n      = 1'b0;
    ack1_n      = 1'b0;
    init_done_n = init_done_q;
    last_n      = last_q;
`ifdef LCD_INIT_SEQ_EN
    idx_n       = idx_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_n  = '0;
        busy_n = 1'b0;
        if (!init_done_q) begin
`ifndef LCD_INIT_SEQ_EN
          init_done_n = 1'b1;
`endif
        end else if (bus.req0 || bus.req1) begin
          state_n = SETUP;
          busy_n  = 1'b1;
          last_n  = pick1;
          ack0_n  = !pick1;
          ack1_n  = pick1;
          d_n     = pick1 ? bus.data1 : bus.data0;
          rs_n    = pick1 ? bus.rs1 : bus.rs0;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_n = EHIGH;
          cnt_n   = '0;
          e_n     = 1'b1;
        end
      end
      EHIGH: begin
        e_n = 1'b1;
        if (cnt_q == CW'(EHIGH_CYC - 1)) begin
          state_n = HOLD;
          cnt_n   = '0;
          e_n     = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_n = EXEC;
          cnt_n   = '0;
        end
      end
      EXEC: begin
        if (cnt_q == exec_last) begin
          cnt_n = '0;
`ifdef LCD_INIT_SEQ_EN
          if (!init_done_q && (idx_q != 3'd5)) begin
            state_n = SETUP;
            idx_n   = idx_q + 3'd1;
            d_n     = init_cmd(idx_q + 3'd1);
            rs_n    = 1'b0;
          end else begin
            state_n     = IDLE;
            busy_n      = 1'b0;
            init_done_n = 1'b1;
          end
`else
          state_n = IDLE;
          busy_n  = 1'b0;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      INIT_WAIT: begin
        if (cnt_q == CW'(POWERUP_CYC - 1)) begin
          state_n = SETUP;
          cnt_n   = '0;
          busy_n  = 1'b1;
          idx_n   = 3'd0;
          d_n     = init_cmd(3'd0);
          rs_n    = 1'b0;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; synchronous reset discards any write in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      d_q         <= 8'h00;
      rs_q        <= 1'b0;
      e_q         <= 1'b0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      init_done_q <= 1'b0;
      last_q      <= 1'b1;
`ifdef LCD_INIT_SEQ_EN
      idx_q       <= 3'd0;
`endif
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      d_q         <= d_n;
      rs_q        <= rs_n;
      e_q         <= e_n;
      busy_q      <= busy_n;
      ack0_q      <= ack0_n;
      ack1_q      <= ack1_n;
      init_done_q <= init_done_n;
      last_q      <= last_n;
`ifdef LCD_INIT_SEQ_EN
      idx_q       <= idx_n;
`endif
    end
  end

  assign bus.d         = d_q;
  assign bus.rs        = rs_q;
  assign bus.e         = e_q;
  assign bus.busy      = busy_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb_lcd_bus_scheduler: directed table/sequence tests plus random traffic
// checked every cycle against a write-duration reference model.
module tb_lcd_bus_scheduler;

  localparam int P_SETUP = 1;
  localparam int P_EHIGH = 2;
  localparam int P_HOLD  = 1;
  localparam int P_EXEC  = 4;
  localparam int P_LONG  = 10;
  localparam int P_POWER = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_scheduler_if bus ();

  lcd_bus_scheduler #(
    .SETUP_CYC(P_SETUP), .EHIGH_CYC(P_EHIGH), .HOLD_CYC(P_HOLD),
    .EXEC_CYC(P_EXEC), .LONG_EXEC_CYC(P_LONG), .POWERUP_CYC(P_POWER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a write is a count k of busy cycles (1..total), idle when 0.
  int         m_k, m_total, m_pw, m_ii;
  logic       m_last, m_init, m_a0, m_a1, m_rs;
  logic [7:0] m_d;
  logic [7:0] init_cmds [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  typedef struct {
    logic       req1;
    logic       rs1;
    logic [7:0] data1;
    logic       ack0;
    logic       ack1;
    logic       busy;
    logic       e;
    logic [7:0] d;
    logic       rs;
  } vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         len;
  } lx_t;

  vec_t       tbl [10];
  lx_t        lx  [5];
  logic [7:0] seen [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_write(input logic rs_v, input logic [7:0] d_v);
    m_d     = d_v;
    m_rs    = rs_v;
    m_k     = 1;
    m_total = P_SETUP + P_EHIGH + P_HOLD +
              ((!rs_v && (d_v inside {8'h01, 8'h02, 8'h03})) ? P_LONG : P_EXEC);
  endtask

  task automatic model_step(input logic rst, input logic q0, input logic s0, input logic [7:0] v0,
                            input logic q1, input logic s1, input logic [7:0] v1);
    logic w1;
    m_a0 = 1'b0;
    m_a1 = 1'b0;
    if (rst) begin
      m_k = 0; m_total = 0; m_d = 8'h00; m_rs = 1'b0; m_last = 1'b1; m_init = 1'b0;
      m_pw = P_POWER; m_ii = 0;
      return;
    end
    if (m_k != 0) begin
      if (m_k < m_total) m_k++;
      else begin
        m_k = 0;
`ifdef LCD_INIT_SEQ_EN
        if (!m_init) begin
          if (m_ii < 6) begin start_write(1'b0, init_cmds[m_ii]); m_ii++; end
          else m_init = 1'b1;
        end
`endif
      end
    end else if (!m_init) begin
`ifdef LCD_INIT_SEQ_EN
      if (m_pw > 0) begin
        m_pw--;
        if (m_pw == 0) begin start_write(1'b0, init_cmds[0]); m_ii = 1; end
      end
`else
      m_init = 1'b1;
`endif
    end else if (q0 || q1) begin
      w1 = q1 && (!q0 || (m_last == 1'b0));
      m_last = w1;
      if (w1) begin m_a1 = 1'b1; start_write(s1, v1); end
      else    begin m_a0 = 1'b1; start_write(s0, v0); end
    end
  endtask

  // One clock: capture inputs, advance model, compare every output after the edge.
  task automatic tick();
    logic r, q0, s0, q1, s1;
    logic [7:0] v0, v1;
    r = reset; q0 = bus.req0; s0 = bus.rs0; v0 = bus.data0;
    q1 = bus.req1; s1 = bus.rs1; v1 = bus.data1;
    @(posedge clk);
    #1;
    model_step(r, q0, s0, v0, q1, s1, v1);
    chk("model_ack0", 32'(bus.ack0), 32'(m_a0));
    chk("model_ack1", 32'(bus.ack1), 32'(m_a1));
    chk("model_busy", 32'(bus.busy), 32'(m_k != 0));
    chk("model_e", 32'(bus.e), 32'((m_k > P_SETUP) && (m_k <= P_SETUP + P_EHIGH)));
    chk("model_d", 32'(bus.d), 32'(m_d));
    chk("model_rs", 32'(bus.rs), 32'(m_rs));
    chk("model_init_done", 32'(bus.init_done), 32'(m_init));
  endtask

  task automatic wait_ack(output int who);
    who = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus.ack0) begin who = 0; break; end
      if (bus.ack1) begin who = 1; break; end
    end
  endtask

  // Counts busy cycles from the current one; returns in the first idle cycle.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) break;
      n++;
      tick();
    end
  endtask

  task automatic clear_inputs();
    bus.req0 = 1'b0; bus.rs0 = 1'b0; bus.data0 = 8'h00;
    bus.req1 = 1'b0; bus.rs1 = 1'b0; bus.data1 = 8'h00;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_d", 32'(bus.d), 32'h0);
    chk("reset_e", 32'(bus.e), 32'h0);
    chk("reset_rs", 32'(bus.rs), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_acks", 32'({bus.ack0, bus.ack1}), 32'h0);
    chk("reset_init_done", 32'(bus.init_done), 32'h0);
    reset = 1'b0;
`ifndef LCD_INIT_SEQ_EN
    tick();
    chk("init_done_after_reset", 32'(bus.init_done), 32'h1);
`endif
  endtask

  initial begin
    int w, n;
    logic pe, got;
    clear_inputs();

    tbl[0] = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 8'h41, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 1'b1};

    lx[0] = '{1'b0, 8'h01, 14};
    lx[1] = '{1'b0, 8'h03, 14};
    lx[2] = '{1'b0, 8'h04, 8};
    lx[3] = '{1'b1, 8'h01, 8};
    lx[4] = '{1'b0, 8'h00, 8};

    reset_dut();

`ifndef LCD_INIT_SEQ_EN
    // Single write from port 1, cycle by cycle.
    for (int i = 0; i < 10; i++) begin
      bus.req1 = tbl[i].req1; bus.rs1 = tbl[i].rs1; bus.data1 = tbl[i].data1;
      tick();
      chk($sformatf("t1_ack0_%0d", i), 32'(bus.ack0), 32'(tbl[i].ack0));
      chk($sformatf("t1_ack1_%0d", i), 32'(bus.ack1), 32'(tbl[i].ack1));
      chk($sformatf("t1_busy_%0d", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("t1_e_%0d", i), 32'(bus.e), 32'(tbl[i].e));
      chk($sformatf("t1_d_%0d", i), 32'(bus.d), 32'(tbl[i].d));
      chk($sformatf("t1_rs_%0d", i), 32'(bus.rs), 32'(tbl[i].rs));
    end

    // Simultaneous requests after reset: strict alternation starting at port 0.
    reset_dut();
    bus.req0 = 1'b1; bus.rs0 = 1'b0; bus.data0 = 8'h80;
    bus.req1 = 1'b1; bus.rs1 = 1'b1; bus.data1 = 8'h35;
    wait_ack(w);
    chk("t2_first_winner", 32'(w), 32'(0));
    chk("t2_first_d", 32'(bus.d), 32'h80);
    bus.req0 = 1'b0;
    count_busy(n);
    chk("t2_busy_len", 32'(n), 32'(8));
    tick();
    chk("t2_p1_first_idle", 32'(bus.ack1), 32'h1);
    chk("t2_p1_d", 32'(bus.d), 32'h35);
    bus.req0 = 1'b1;
    count_busy(n);
    tick();
    chk("t2_alternate_ack0", 32'(bus.ack0), 32'h1);
    chk("t2_alternate_ack1", 32'(bus.ack1), 32'h0);
    clear_inputs();
    count_busy(n);

    // Exec wait length at and around the clear/home command boundary.
    for (int i = 0; i < 5; i++) begin
      bus.req0 = 1'b1; bus.rs0 = lx[i].rs; bus.data0 = lx[i].d;
      wait_ack(w);
      chk($sformatf("t3_winner_%0d", i), 32'(w), 32'(0));
      bus.req0 = 1'b0;
      count_busy(n);
      chk($sformatf("t3_busy_len_%0d", i), 32'(n), 32'(lx[i].len));
    end

    // Request withdrawn while busy produces no write.
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h55;
    wait_ack(w);
    bus.req0 = 1'b0;
    tick(); tick();
    bus.req1 = 1'b1; bus.rs1 = 1'b1; bus.data1 = 8'h99;
    tick(); tick(); tick();
    bus.req1 = 1'b0;
    count_busy(n);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t4_no_ack1_%0d", i), 32'(bus.ack1), 32'h0);
      chk($sformatf("t4_no_e_%0d", i), 32'(bus.e), 32'h0);
      chk($sformatf("t4_d_kept_%0d", i), 32'(bus.d), 32'h55);
    end

    // Reset during E high aborts the write; the held request is re-granted.
    bus.req0 = 1'b1; bus.rs0 = 1'b1; bus.data0 = 8'h12;
    wait_ack(w);
    for (int i = 0; i < 20; i++) begin
      if (bus.e) break;
      tick();
    end
    chk("t5_reached_ehigh", 32'(bus.e), 32'h1);
    reset = 1'b1;
    tick();
    chk("t5_e", 32'(bus.e), 32'h0);
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_d", 32'(bus.d), 32'h0);
    chk("t5_rs", 32'(bus.rs), 32'h0);
    reset = 1'b0;
    wait_ack(w);
    chk("t5_regrant", 32'(w), 32'(0));
    chk("t5_regrant_d", 32'(bus.d), 32'h12);
    bus.req0 = 1'b0;
    count_busy(n);
`else
    // Power-up sequence, with a port 1 request pending throughout.
    bus.req1 = 1'b1; bus.rs1 = 1'b1; bus.data1 = 8'h41;
    pe = 1'b0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      if (bus.e && !pe) seen.push_back(bus.d);
      pe = bus.e;
      if (bus.ack1) begin
        got = 1'b1;
        chk("t6_init_done_at_ack", 32'(bus.init_done), 32'h1);
        chk("t6_pulses_before_ack", 32'(seen.size()), 32'(6));
      end
    end
    chk("t6_ack1_seen", 32'(got), 32'h1);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      chk($sformatf("t6_cmd_%0d", i), 32'(seen[i]), 32'(init_cmds[i]));
    bus.req1 = 1'b0;
    count_busy(n);
`endif

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req0 = ~bus.req0;
      if ($urandom_range(0, 3) == 0) bus.req1 = ~bus.req1;
      if ($urandom_range(0, 2) == 0) begin
        bus.rs0   = 1'($urandom_range(0, 1));
        bus.data0 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        bus.rs1   = 1'($urandom_range(0, 1));
        bus.data1 = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      end
      reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    clear_inputs();
    for (int i = 0; i < 40; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_bus_scheduler.md
Name: lcd_bus_scheduler

Overview:
- Owns the single HD44780-style 8-bit LCD bus (d, e, rs).
- Arbitrates write requests from two clients: port 0 (screen/command client) and port 1 (live-value client fed from the SPI/converter path).
- Generates E strobe timing and per-command execution waits, so clients never need to track LCD timing.
- Sits between the display-content logic and the LCD pins.

Parameters:
- SETUP_CYC, 4: cycles d/rs are stable before E rises.
- EHIGH_CYC, 24: cycles E is held high.
- HOLD_CYC, 4: cycles d/rs are held after E falls.
- EXEC_CYC, 2000: wait after a normal command or data write.
- LONG_EXEC_CYC, 80000: wait after a clear or home command.
- POWERUP_CYC, 800000: power-on delay. Used only with LCD_INIT_SEQ_EN.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- req0, in, 1: port 0 write request.
- rs0, in, 1: port 0 register select (0 = command, 1 = data).
- data0, in, 8: port 0 byte.
- ack0, out, 1: one-cycle pulse; port 0 write accepted.
- req1 / rs1 / data1 / ack1: same as port 0, for port 1.
- d, out, 8: LCD data bus.
- e, out, 1: LCD enable strobe.
- rs, out, 1: LCD register select.
- busy, out, 1: high while a write is in progress.
- init_done, out, 1: high once client requests may be served.

Behaviour:
- Reset: state IDLE (or INIT_WAIT with the macro). d=0, rs=0, e=0, ack0=ack1=0, busy=0, init_done=0. Round-robin pointer favours port 0. All counters cleared.
- Reset asserted mid-write: the next edge forces e=0 and discards the write. No ack is issued for it.
- All outputs are registered.
- Handshake:
  - A client holds req with rs/data stable until it sees ack.
  - Dropping req before ack withdraws the request; no write occurs.
  - After ack, the client may change data immediately.
  - Holding req high after ack is treated as a new request.
- States: IDLE, SETUP, EHIGH, HOLD, EXEC.
- IDLE (init_done=1):
  - If either req is high: pick a winner, latch its rs/data into rs/d, pulse its ack for exactly one cycle, set busy=1, go to SETUP.
  - If both are high: the port opposite the last winner wins, then the pointer updates.
  - If neither is high: stay in IDLE, busy=0.
- SETUP: SETUP_CYC cycles, e=0. Then go to EHIGH.
- EHIGH: EHIGH_CYC cycles, e=1. Then go to HOLD.
- HOLD: HOLD_CYC cycles, e=0, d/rs held. Then go to EXEC.
- EXEC wait length:
  - LONG_EXEC_CYC if the latched write has rs=0 and d[7:2]=0 and d[1:0]≠0 (0x01, 0x02, 0x03).
  - Otherwise EXEC_CYC.
- EXEC exit: return to IDLE with busy=0 on the edge after the last EXEC cycle. d/rs keep their last value.
- Throughput: busy stays high for exactly SETUP+EHIGH+HOLD+exec cycles. The next grant can occur in the first IDLE cycle.
- Requests arriving while busy stay pending and are not dropped. They are served, subject to the round-robin rule, on return to IDLE.
- ack is never asserted outside the IDLE→SETUP transition. ack0 and ack1 are never high together.
- Counter width: clog2 of the largest parameter, +1. Each phase counter reloads on state entry. A parameter value of 0 is illegal; the minimum is 1.

Optional Feature:
- Macro: LCD_INIT_SEQ_EN.
- Defined:
  - After reset, enter INIT_WAIT for POWERUP_CYC cycles.
  - Then issue the built-in command list 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 (all rs=0) through the same SETUP/EHIGH/HOLD/EXEC path. 0x01 uses LONG_EXEC_CYC.
  - No client acks are issued during this sequence; requests stay pending.
  - init_done rises on return to IDLE after 0x06.
- Not defined:
  - No INIT_WAIT; init_done=1 starting one cycle after reset deasserts.
  - Clients are responsible for LCD initialisation.

Test Plan:
- Parameter overrides for all tests: SETUP=1, EHIGH=2, HOLD=1, EXEC=4, LONG=10, POWERUP=5.
1. Single write. req1 with rs1=1, data1=0x41 in IDLE.
   - Next cycle: ack1 pulses once, d=0x41, rs=1, busy=1.
   - e high for exactly 2 cycles, starting 1 cycle after ack.
   - busy high for 8 cycles total; ack0 stays 0.
2. Simultaneous requests after reset. req0 (0x80, rs0=0) and req1 (0x35, rs1=1) both held.
   - Port 0 is granted first.
   - Port 1 is granted in the first IDLE cycle after busy falls.
   - Then, with both held again, port 0 wins next (strict alternation).
3. Long-exec command. Port 0 writes rs0=0, data0=0x01.
   - busy high for 14 cycles.
   - Repeat with 0x04: busy high for 8 cycles.
4. Withdrawn request. req1 raised while busy, dropped before IDLE.
   - No ack1 is issued, no E strobe follows, and d keeps its old value.
5. Reset during EHIGH.
   - The next edge gives e=0, busy=0, d=0, rs=0, state IDLE.
   - The pending req0 is then granted with a fresh ack0.
6. With LCD_INIT_SEQ_EN.
   - After reset: 5 idle cycles, then six e pulses carrying d=0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
   - init_done rises only after this sequence.
   - A req1 held throughout is acked only after init_done.
